// File: rtl/nn_data_path.sv
// nn_data_path: code/weight/input/label memories feeding a fetch -> decode/execute pipeline.
// Define MAC_SATURATE_EN to clamp the accumulator on signed overflow; otherwise it wraps.
module nn_data_path #(
    parameter int unsigned CODE_DEPTH = 64,
    parameter int unsigned LAYERS     = 4,
    parameter int unsigned ROWS       = 8
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        code_storage_write_interface_is_write,
    input  logic [31:0] code_storage_write_interface_write_line,
    input  logic [11:0] code_storage_write_interface_write_data,
    input  logic        code_storage_enable_interface_enable,
    input  logic        controller_enable_interface_enable,
    input  logic        weight_storage_is_write_interface_is_write,
    input  logic [31:0] weight_storage_write_interface_write_layer_index,
    input  logic [31:0] weight_storage_write_interface_write_row_index,
    input  logic [47:0] weight_storage_write_interface_write_data,
    input  logic        input_storage_is_write_interface_is_write,
    input  logic [31:0] input_storage_write_interface_write_layer_index,
    input  logic [31:0] input_storage_write_interface_write_row_index,
    input  logic [47:0] input_storage_write_interface_write_data,
    input  logic        label_storage_is_write_interface_is_write,
    input  logic [31:0] label_storage_write_interface_write_layer_index,
    input  logic [31:0] label_storage_write_interface_write_row_index,
    input  logic [47:0] label_storage_write_interface_write_data,
    input  logic        matrix_storage_locator_reset_interface_reset,
    output logic [31:0] fetch_to_decode_register_code_index_out_interface_code_index
);

    localparam int unsigned INSTR_W   = 12;
    localparam int unsigned ELEM_W    = 16;
    localparam int unsigned ROW_W     = 3 * ELEM_W;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned SUM_W     = ACC_W + 3;
    localparam int unsigned IDX_W     = 32;
    localparam int unsigned PC_W      = (CODE_DEPTH > 1) ? $clog2(CODE_DEPTH) : 1;
    localparam int unsigned LAYER_W   = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    localparam int unsigned ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned MAT_DEPTH = LAYERS * ROWS;
    localparam int unsigned MAT_W     = (MAT_DEPTH > 1) ? $clog2(MAT_DEPTH) : 1;

    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_HALT = 4'h2;
    localparam logic [3:0] OP_CLR  = 4'h3;
    localparam logic [3:0] OP_MAC  = 4'h4;
    localparam logic [3:0] OP_NEXT = 4'h5;
    localparam logic [3:0] OP_SUBL = 4'h6;
    localparam logic [INSTR_W-1:0] NOP_WORD = 12'h000;

`ifdef MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] ACC_MIN = 32'sh8000_0000;
`endif

    typedef struct packed {
        logic               valid;
        logic [PC_W-1:0]    index;
        logic [INSTR_W-1:0] instr;
    } fd_reg_t;

    logic [INSTR_W-1:0] code_mem   [CODE_DEPTH];
    logic [ROW_W-1:0]   weight_mem [MAT_DEPTH];
    logic [ROW_W-1:0]   input_mem  [MAT_DEPTH];
    logic [ROW_W-1:0]   label_mem  [MAT_DEPTH];

    logic [PC_W-1:0]         pc;
    fd_reg_t                 fd_q;
    logic                    halted;
    logic signed [ACC_W-1:0] acc;
    logic [LAYER_W-1:0]      loc_layer;
    logic [ROW_IDX_W-1:0]    loc_row;

    function automatic logic mat_in_range(input logic [IDX_W-1:0] layer,
                                          input logic [IDX_W-1:0] row);
        return (layer < IDX_W'(LAYERS)) && (row < IDX_W'(ROWS));
    endfunction

    function automatic logic [MAT_W-1:0] mat_addr(input logic [IDX_W-1:0] layer,
                                                   input logic [IDX_W-1:0] row);
        return MAT_W'(layer * IDX_W'(ROWS) + row);
    endfunction

    // Accumulator plus the three 32-bit element products, kept wide so overflow is visible.
    function automatic logic signed [SUM_W-1:0] mac_total(input logic signed [ACC_W-1:0] a,
                                                          input logic [ROW_W-1:0] w,
                                                          input logic [ROW_W-1:0] x);
        logic signed [SUM_W-1:0]  s;
        logic signed [ELEM_W-1:0] we;
        logic signed [ELEM_W-1:0] xe;
        logic signed [ACC_W-1:0]  p;
        s = SUM_W'(a);
        for (int i = 0; i < 3; i++) begin
            we = w[i*ELEM_W +: ELEM_W];
            xe = x[i*ELEM_W +: ELEM_W];
            p  = ACC_W'(we) * ACC_W'(xe);
            s  = s + SUM_W'(p);
        end
        return s;
    endfunction

    function automatic logic signed [ACC_W-1:0] fit_acc(input logic signed [SUM_W-1:0] s);
`ifdef MAC_SATURATE_EN
        if (s > SUM_W'(ACC_MAX)) return ACC_MAX;
        if (s < SUM_W'(ACC_MIN)) return ACC_MIN;
`endif
        return ACC_W'(s);
    endfunction

    // Host writes; out-of-range addresses are dropped rather than wrapped.
    always_ff @(posedge clk_clk) begin
        if (code_storage_write_interface_is_write &&
            (code_storage_write_interface_write_line < IDX_W'(CODE_DEPTH))) begin
            code_mem[PC_W'(code_storage_write_interface_write_line)] <=
                code_storage_write_interface_write_data;
        end
        if (weight_storage_is_write_interface_is_write &&
            mat_in_range(weight_storage_write_interface_write_layer_index,
                         weight_storage_write_interface_write_row_index)) begin
            weight_mem[mat_addr(weight_storage_write_interface_write_layer_index,
                                weight_storage_write_interface_write_row_index)] <=
                weight_storage_write_interface_write_data;
        end
        if (input_storage_is_write_interface_is_write &&
            mat_in_range(input_storage_write_interface_write_layer_index,
                         input_storage_write_interface_write_row_index)) begin
            input_mem[mat_addr(input_storage_write_interface_write_layer_index,
                               input_storage_write_interface_write_row_index)] <=
                input_storage_write_interface_write_data;
        end
        if (label_storage_is_write_interface_is_write &&
            mat_in_range(label_storage_write_interface_write_layer_index,
                         label_storage_write_interface_write_row_index)) begin
            label_mem[mat_addr(label_storage_write_interface_write_layer_index,
                               label_storage_write_interface_write_row_index)] <=
                label_storage_write_interface_write_data;
        end
    end

    // Asynchronous reads: a same-edge write is not yet visible, so reads see old data.
    logic [MAT_W-1:0]         loc_addr;
    logic [INSTR_W-1:0]       fetch_instr;
    logic [ROW_W-1:0]         weight_row;
    logic [ROW_W-1:0]         input_row;
    logic [ROW_W-1:0]         label_row;
    logic signed [ELEM_W-1:0] label_e0;
    logic                     unused_label_hi;

    assign loc_addr        = mat_addr(IDX_W'(loc_layer), IDX_W'(loc_row));
    assign fetch_instr     = code_mem[pc];
    assign weight_row      = weight_mem[loc_addr];
    assign input_row       = input_mem[loc_addr];
    assign label_row       = label_mem[loc_addr];
    assign label_e0        = label_row[ELEM_W-1:0];
    assign unused_label_hi = ^label_row[ROW_W-1:ELEM_W];

    logic                    advance;
    logic                    exec;
    logic [3:0]              op;
    logic [7:0]              operand;
    logic                    do_jmp;
    logic                    do_halt;
    logic                    do_next;
    logic [PC_W-1:0]         pc_inc;
    logic [PC_W-1:0]         jmp_target;
    logic signed [SUM_W-1:0] mac_sum;
    logic signed [SUM_W-1:0] sub_sum;

    assign advance    = code_storage_enable_interface_enable &&
                        controller_enable_interface_enable && !halted;
    assign exec       = advance && fd_q.valid;
    assign op         = fd_q.instr[11:8];
    assign operand    = fd_q.instr[7:0];
    assign do_jmp     = exec && (op == OP_JMP);
    assign do_halt    = exec && (op == OP_HALT);
    assign do_next    = exec && (op == OP_NEXT);
    assign pc_inc     = (pc == PC_W'(CODE_DEPTH - 1)) ? '0 : pc + PC_W'(1);
    assign jmp_target = PC_W'(IDX_W'(operand) % IDX_W'(CODE_DEPTH));
    assign mac_sum    = mac_total(acc, weight_row, input_row);
    assign sub_sum    = SUM_W'(acc) - SUM_W'(label_e0);

    // Pipeline, accumulator and locator; reset is synchronous and active-high.
    always_ff @(posedge clk_clk) begin
        if (reset_reset_n) begin
            pc        <= '0;
            fd_q      <= '{valid: 1'b0, index: '0, instr: NOP_WORD};
            halted    <= 1'b0;
            acc       <= '0;
            loc_layer <= '0;
            loc_row   <= '0;
        end else begin
            if (advance) begin
                if (do_halt) begin
                    halted <= 1'b1;
                end else begin
                    // A taken jump squashes the word fetched alongside it but keeps its index.
                    fd_q <= '{valid: !do_jmp, index: pc, instr: fetch_instr};
                    pc   <= do_jmp ? jmp_target : pc_inc;
                end
                if (exec) begin
                    case (op)
                        OP_CLR:  acc <= '0;
                        OP_MAC:  acc <= fit_acc(mac_sum);
                        OP_SUBL: acc <= fit_acc(sub_sum);
                        default: ;
                    endcase
                end
            end
            if (matrix_storage_locator_reset_interface_reset) begin
                loc_layer <= '0;
                loc_row   <= '0;
            end else if (do_next) begin
                if (loc_row == ROW_IDX_W'(ROWS - 1)) begin
                    loc_row   <= '0;
                    loc_layer <= (loc_layer == LAYER_W'(LAYERS - 1)) ? '0
                                                                     : loc_layer + LAYER_W'(1);
                end else begin
                    loc_row <= loc_row + ROW_IDX_W'(1);
                end
            end
        end
    end

    assign fetch_to_decode_register_code_index_out_interface_code_index = IDX_W'(fd_q.index);

endmodule

// File: tb/tb_nn_data_path.sv
// Self-checking bench for nn_data_path: scoreboard of expected code indices plus
// accumulator/locator checks against hand-derived values.
module tb_nn_data_path;

    logic        clk = 1'b0;
    logic        rst;
    logic        code_we;
    logic [31:0] code_line;
    logic [11:0] code_data;
    logic        code_en;
    logic        ctrl_en;
    logic        w_we, x_we, l_we;
    logic [31:0] w_layer, w_row, x_layer, x_row, l_layer, l_row;
    logic [47:0] w_data, x_data, l_data;
    logic        loc_rst;
    logic [31:0] code_index;

    int n_cmp = 0;
    int n_err = 0;
    int sb_q[$];

    nn_data_path dut (
        .clk_clk                                                      (clk),
        .reset_reset_n                                                (rst),
        .code_storage_write_interface_is_write                        (code_we),
        .code_storage_write_interface_write_line                      (code_line),
        .code_storage_write_interface_write_data                      (code_data),
        .code_storage_enable_interface_enable                         (code_en),
        .controller_enable_interface_enable                           (ctrl_en),
        .weight_storage_is_write_interface_is_write                   (w_we),
        .weight_storage_write_interface_write_layer_index             (w_layer),
        .weight_storage_write_interface_write_row_index               (w_row),
        .weight_storage_write_interface_write_data                    (w_data),
        .input_storage_is_write_interface_is_write                    (x_we),
        .input_storage_write_interface_write_layer_index              (x_layer),
        .input_storage_write_interface_write_row_index                (x_row),
        .input_storage_write_interface_write_data                     (x_data),
        .label_storage_is_write_interface_is_write                    (l_we),
        .label_storage_write_interface_write_layer_index              (l_layer),
        .label_storage_write_interface_write_row_index                (l_row),
        .label_storage_write_interface_write_data                     (l_data),
        .matrix_storage_locator_reset_interface_reset                 (loc_rst),
        .fetch_to_decode_register_code_index_out_interface_code_index (code_index)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_index", code_index, 32'd0);
        check("reset_acc", dut.acc, 32'd0);
        check("reset_halted", 32'(dut.halted), 32'd0);
    endtask

    task automatic write_code(input int line, input logic [11:0] word);
        code_we   = 1'b1;
        code_line = 32'(line);
        code_data = word;
        tick();
        code_we   = 1'b0;
    endtask

    task automatic write_mat(input int which, input int layer, input int row,
                             input logic [47:0] data);
        case (which)
            0: begin w_we = 1'b1; w_layer = 32'(layer); w_row = 32'(row); w_data = data; end
            1: begin x_we = 1'b1; x_layer = 32'(layer); x_row = 32'(row); x_data = data; end
            default: begin l_we = 1'b1; l_layer = 32'(layer); l_row = 32'(row); l_data = data; end
        endcase
        tick();
        w_we = 1'b0;
        x_we = 1'b0;
        l_we = 1'b0;
    endtask

    task automatic push_range(input int first, input int last);
        for (int i = first; i <= last; i++) sb_q.push_back(i);
    endtask

    // One clock per queued expectation, comparing the code index after each edge.
    task automatic drain(input string tag);
        int exp;
        while (sb_q.size() > 0) begin
            tick();
            exp = sb_q.pop_front();
            check(tag, code_index, 32'(exp));
        end
    endtask

    initial begin
        rst = 1'b1; code_we = 1'b0; code_line = '0; code_data = '0;
        code_en = 1'b0; ctrl_en = 1'b0; loc_rst = 1'b0;
        w_we = 1'b0; x_we = 1'b0; l_we = 1'b0;
        w_layer = '0; w_row = '0; w_data = '0;
        x_layer = '0; x_row = '0; x_data = '0;
        l_layer = '0; l_row = '0; l_data = '0;
        @(negedge clk);

        // Straight-line NOP program, including PC wrap at the end of code memory.
        do_reset();
        for (int i = 0; i < 64; i++) write_code(i, 12'h000);
        check("idle_index", code_index, 32'd0);
        code_en = 1'b1; ctrl_en = 1'b1;
        for (int k = 1; k <= 66; k++) sb_q.push_back((k - 1) % 64);
        drain("fetch_seq");

        // Execute enable low holds the pipeline; dropping it mid-run freezes and resumes.
        code_en = 1'b1; ctrl_en = 1'b0;
        do_reset();
        repeat (5) sb_q.push_back(0);
        drain("hold_ctrl_off");
        ctrl_en = 1'b1;
        push_range(0, 2);
        drain("run");
        ctrl_en = 1'b0;
        repeat (3) sb_q.push_back(2);
        drain("freeze");
        ctrl_en = 1'b1;
        push_range(3, 4);
        drain("resume");

        // JMP squashes its shadow, HALT sticks until reset.
        code_en = 1'b0; ctrl_en = 1'b0;
        do_reset();
        write_code(0, 12'h105);
        write_code(5, 12'h200);
        code_en = 1'b1; ctrl_en = 1'b1;
        sb_q.push_back(0); sb_q.push_back(1);
        repeat (5) sb_q.push_back(5);
        drain("jmp_halt");
        check("halted_set", 32'(dut.halted), 32'd1);
        do_reset();
        sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(5); sb_q.push_back(5);
        drain("after_reset_rerun");

        // JMP operand is taken modulo the code depth; out-of-range writes are dropped.
        code_en = 1'b0; ctrl_en = 1'b0;
        do_reset();
        write_code(0, 12'h147);
        write_code(7, 12'h200);
        write_code(64, 12'h200);
        write_code(-1, 12'h200);
        code_en = 1'b1; ctrl_en = 1'b1;
        sb_q.push_back(0); sb_q.push_back(1);
        repeat (3) sb_q.push_back(7);
        drain("jmp_mod");

        // CLR, MAC, MAC, SUBL, HALT over L0/R0.
        code_en = 1'b0; ctrl_en = 1'b0;
        do_reset();
        write_mat(0, 0, 0, {16'd1, 16'd2, 16'd3});
        write_mat(1, 0, 0, {16'd4, 16'd5, 16'd6});
        write_mat(2, 0, 0, {16'd0, 16'd0, 16'd10});
        write_mat(0, 4, 0, {16'd7, 16'd7, 16'd7});
        write_mat(1, 0, 8, {16'd7, 16'd7, 16'd7});
        write_code(0, 12'h300);
        write_code(1, 12'h400);
        write_code(2, 12'h400);
        write_code(3, 12'h600);
        write_code(4, 12'h200);
        code_en = 1'b1; ctrl_en = 1'b1;
        push_range(0, 2);
        drain("mac_prog");
        check("acc_one_mac", dut.acc, 32'd32);
        // Overwrite the weight row on the same edge the second MAC reads it.
        w_we = 1'b1; w_layer = 32'd0; w_row = 32'd0; w_data = '0;
        sb_q.push_back(3);
        drain("mac_prog");
        w_we = 1'b0;
        check("acc_two_mac_old_data", dut.acc, 32'd64);
        repeat (3) sb_q.push_back(4);
        drain("subl_prog");
        check("acc_after_subl", dut.acc, 32'd54);

        // Nine NEXTs walk the locator to L1/R1; locator reset clears it and beats NEXT.
        code_en = 1'b0; ctrl_en = 1'b0;
        do_reset();
        for (int i = 0; i < 9; i++) write_code(i, 12'h500);
        write_code(9, 12'h200);
        code_en = 1'b1; ctrl_en = 1'b1;
        push_range(0, 9);
        sb_q.push_back(9); sb_q.push_back(9);
        drain("next_prog");
        check("loc_layer", 32'(dut.loc_layer), 32'd1);
        check("loc_row", 32'(dut.loc_row), 32'd1);
        code_en = 1'b0; ctrl_en = 1'b0;
        loc_rst = 1'b1;
        tick();
        loc_rst = 1'b0;
        check("loc_layer_cleared", 32'(dut.loc_layer), 32'd0);
        check("loc_row_cleared", 32'(dut.loc_row), 32'd0);
        do_reset();
        loc_rst = 1'b1;
        code_en = 1'b1; ctrl_en = 1'b1;
        push_range(0, 9);
        sb_q.push_back(9);
        drain("next_with_loc_rst");
        loc_rst = 1'b0;
        check("loc_prio_layer", 32'(dut.loc_layer), 32'd0);
        check("loc_prio_row", 32'(dut.loc_row), 32'd0);

        // Drive the accumulator to 0x7FFFFFF0 and add 0x100.
        code_en = 1'b0; ctrl_en = 1'b0;
        do_reset();
        write_mat(0, 0, 0, {16'd1, 16'h8000, 16'h8000});
        write_mat(1, 0, 0, {16'h7FF0, 16'h8001, 16'h8000});
        write_mat(0, 0, 1, {16'd0, 16'd0, 16'd16});
        write_mat(1, 0, 1, {16'd0, 16'd0, 16'd16});
        write_code(0, 12'h300);
        write_code(1, 12'h400);
        write_code(2, 12'h500);
        write_code(3, 12'h400);
        write_code(4, 12'h200);
        code_en = 1'b1; ctrl_en = 1'b1;
        push_range(0, 2);
        drain("sat_prog");
        check("acc_near_max", dut.acc, 32'h7FFF_FFF0);
        sb_q.push_back(3); sb_q.push_back(4); sb_q.push_back(4);
        drain("sat_prog");
`ifdef MAC_SATURATE_EN
        check("acc_overflow", dut.acc, 32'h7FFF_FFFF);
`else
        check("acc_overflow", dut.acc, 32'h8000_00F0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
